led_blink_sched: RTL and testbench
==================================

# led_blink_sched

Round-robin scheduler that shares the single board LED (`led1`) between up to `N_REQ` requesters. Each requester asks for a burst of N blinks. The block grants one requester at a time, drives the blink burst with exact on/off phase timing derived from the 50 MHz clock, and inserts a dark gap between bursts. It then signals completion back to the granted requester. It sits between status sources (heartbeat, error, button logic) and the LED pin.

## Interface
- `HALF_PERIOD`, default 25_000_000: clock cycles per LED on-phase and per off-phase (0.5 s at 50 MHz); must be ≥ 2.
- `GAP_CYCLES`, default 50_000_000: dark cycles after every burst, before `done`; must be ≥ 1.
- `N_REQ`, default 4: number of requesters, 2..8.
- `CNT_W`, default 4: width of each blink-count field.
- `clk` in 1: system clock, 50 MHz crystal.
- `rst` in 1: reset; asynchronous, active-high.
- `req` in N_REQ: level request per requester; held until granted.
- `req_blinks` in N_REQ*CNT_W: blink count; requester i uses bits [i*CNT_W +: CNT_W].
- `gnt` out N_REQ: one-hot, one-cycle pulse when a request is accepted.
- `done` out N_REQ: one-hot, one-cycle pulse when the granted burst plus gap has finished.
- `busy` out 1: high from grant until the `done` pulse (inclusive).
- `led1` out 1: LED drive; 1 = lit.

## Operation
- States: IDLE, ON, OFF, GAP.
- **IDLE:**
  - If `req` != 0, grant the first set bit at or after `ptr`, searching upward with wrap.
  - On grant, latch `req_blinks` of the granted requester into `remaining` and latch its index.
  - Set `ptr` = index+1, mod N_REQ.
  - Pulse `gnt`[index] and set `busy`.
  - Next state is ON if `remaining` != 0, else GAP.
- **ON:** `led1`=1 for HALF_PERIOD cycles, then go to OFF and decrement `remaining`.
- **OFF:** `led1`=0 for HALF_PERIOD cycles, then go to ON if `remaining` != 0, else GAP.
- **GAP:** `led1`=0 for GAP_CYCLES cycles, then pulse `done`[index], clear `busy`, go to IDLE.
- Requests:
  - `req` and `req_blinks` are sampled only in IDLE.
  - Changes while busy are ignored.
  - A requester still holding `req` after its `done` is re-arbitrated normally. Round-robin then favours the others.
- Phase counter:
  - Width is $clog2(max(HALF_PERIOD, GAP_CYCLES)).
  - It loads 0 on each state entry and counts 0..limit-1, so each phase is exactly limit cycles.
- `remaining`:
  - CNT_W bits, decremented only on ON→OFF, never below 0.
  - Maximum burst is 2^CNT_W − 1 blinks.
- Reset (asserted at any time, including mid-burst):
  - Go to IDLE immediately.
  - Clear `led1`, `gnt`, `done`, `busy`, `ptr`, `remaining` and the counter.
  - The interrupted burst is abandoned and produces no `done`.

## Timing
- All outputs are registered.
- Reset values: `led1`=0, `gnt`=0, `done`=0, `busy`=0.
- Grant latency: `req` seen high at edge k gives `gnt` and `busy` high after edge k. For a nonzero count, `led1`=1 from the same edge.
- Burst of n ≥ 1 blinks: `led1` high for HALF_PERIOD cycles, low for HALF_PERIOD cycles, repeated n times. Then GAP_CYCLES dark cycles.
- `done` pulses in the final GAP cycle+1, which is the IDLE entry edge.
- Grant-to-done: exactly 2·n·HALF_PERIOD + GAP_CYCLES cycles.
- Zero-count request: gnt, then GAP_CYCLES dark cycles, then `done`.
- Back-to-back: the earliest next `gnt` is the cycle after `done` (one IDLE cycle minimum).
- Simultaneous requests in the same cycle: the round-robin pointer decides; no request is lost. The others wait.

## Structure
- Package `led_sched_pkg` holds:
  - the `state_t` enum (IDLE, ON, OFF, GAP);
  - a helper function for round-robin index search.
- Sub-module `led_phase_timer`:
  - counter with `load`, `limit` input and a one-cycle `expire` output;
  - instanced once and reused by all three timed states.

## Test plan
Sim parameters: HALF_PERIOD=4, GAP_CYCLES=3, N_REQ=4, CNT_W=4.
- **Single 2-blink request:** `req`=0001, blinks=2 → `gnt`=0001 one cycle. `led1` pattern 1111 0000 1111 0000 then 000. `done`=0001 at grant+19, `busy` low after.
- **Zero-count request:** `req`=0100, blinks=0 → `gnt`=0100, `led1` stays 0, `done`=0100 exactly 3 cycles after grant.
- **All four requesting, blinks=1 each, held until done:** grant order 0,1,2,3,0. Each grant exactly one cycle after the previous `done`.
- **Reset mid-operation:** `rst` pulsed during the second ON phase of a 3-blink burst → `led1`, `busy` 0 immediately. No `done` ever pulses; the next grant goes to requester 0.
- **Max count:** blinks=15 → exactly 15 rising edges on `led1`; `done` at grant+123.
- **`req_blinks` changed mid-burst:** 2 → 9 while busy → burst still 2 blinks.

Source files
------------

// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED blink scheduler.
//   state_t : scheduler FSM states (IDLE, ON, OFF, GAP)
//   MAX_REQ : upper bound on the number of requesters
//   rr_pick : round-robin search that returns the first set request bit
//             at or after a start pointer, wrapping modulo n
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int MAX_REQ = 8;

  // The loop walks the offsets from highest to lowest, so the last hit it
  // records is the one closest to ptr. The bound is fixed so that the loop
  // unrolls to a static structure, and offsets >= n are skipped.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                 input int ptr,
                                 input int n);
    int pick;
    int idx;
    pick = 0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (ptr + i) % n;
        if (req[idx[2:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/led_phase_timer.sv
// Phase timer shared by the ON, OFF and GAP states.
//   clk, rst : clock and asynchronous active-high reset
//   load     : restart the count at 0 (asserted on every state entry)
//   limit    : phase length in cycles; W+1 bits wide so that a limit of
//              exactly 2^W still fits
//   expire   : high during the last cycle of the phase (count == limit-1)
module led_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W:0]   limit,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The owner loads on every expire, so the counter never runs past limit-1.
  assign expire = ({1'b0, cnt} == (limit - (W+1)'(1)));

endmodule

// File: rtl/led_blink_sched.sv
// Round-robin scheduler that shares one LED between N_REQ requesters.
// Each grant plays a burst of blinks (HALF_PERIOD on, HALF_PERIOD off per
// blink), then GAP_CYCLES dark cycles, then pulses done to the requester.
//   clk        : system clock
//   rst        : asynchronous active-high reset; abandons any burst
//   req        : level request per requester, sampled only while idle
//   req_blinks : CNT_W-bit blink count per requester, packed by index
//   gnt        : one-hot single-cycle pulse on acceptance
//   done       : one-hot single-cycle pulse when burst plus gap completes
//   busy       : high from grant through the done cycle
//   led1       : LED drive, 1 = lit
module led_blink_sched
  import led_sched_pkg::*;
#(
  parameter int HALF_PERIOD = 25_000_000,
  parameter int GAP_CYCLES  = 50_000_000,
  parameter int N_REQ       = 4,
  parameter int CNT_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CNT_W-1:0]   req_blinks,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     led1
);

  localparam int MAX_LIM = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_LIM);
  localparam int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CW:0] HALF_LIM = (CW+1)'(HALF_PERIOD);
  localparam logic [CW:0] GAP_LIM  = (CW+1)'(GAP_CYCLES);

  state_t              state;
  logic [CNT_W-1:0]    remaining;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       idx;

  logic [MAX_REQ-1:0]  req_ext;
  int                  pick;
  logic [N_REQ-1:0]    pick_oh;
  logic [CNT_W-1:0]    pick_blinks;
  logic [CW:0]         limit;
  logic                load;
  logic                expire;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    pick                 = rr_pick(req_ext, int'(ptr), N_REQ);
    pick_oh              = N_REQ'(1) << pick;
    pick_blinks          = req_blinks[pick*CNT_W +: CNT_W];
    limit                = (state == GAP) ? GAP_LIM : HALF_LIM;
    // Holding load through IDLE makes the counter start at 0 on the grant
    // edge; every expire coincides with a state change, so it reloads too.
    load                 = (state == IDLE) || expire;
  end

  led_phase_timer #(
    .W (CW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .limit  (limit),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      ptr       <= '0;
      idx       <= '0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      led1      <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          led1 <= 1'b0;
          if (|req) begin
            gnt       <= pick_oh;
            idx       <= PW'(pick);
            ptr       <= PW'((pick + 1) % N_REQ);
            remaining <= pick_blinks;
            busy      <= 1'b1;
            if (pick_blinks != '0) begin
              state <= ON;
              led1  <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        ON: begin
          if (expire) begin
            state <= OFF;
            led1  <= 1'b0;
            if (remaining != '0) remaining <= remaining - 1'b1;
          end
        end
        OFF: begin
          if (expire) begin
            if (remaining != '0) begin
              state <= ON;
              led1  <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          // busy stays high through the done cycle; IDLE clears it.
          if (expire) begin
            done  <= N_REQ'(1) << idx;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_sched.sv
module tb_led_blink_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_blinks;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        led1;

  int total;
  int bad;

  led_blink_sched #(
    .HALF_PERIOD (4),
    .GAP_CYCLES  (3),
    .N_REQ       (4),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_blinks (req_blinks),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .led1       (led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [18:0] ledpat;
    int          early;
    int          lit;
    int          rises;
    logic        prev;
    int          ng;
    int          lastdone;
    logic [19:0] order;

    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    req        = '0;
    req_blinks = '0;
    cyc();
    do_reset();

    // reset state
    chk("rst_outputs", 32'({led1, gnt, done, busy}), 32'h0);

    // single 2-blink request from requester 0
    req_blinks = 16'h0002;
    req        = 4'b0001;
    cyc();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    req    = '0;
    ledpat = '0;
    early  = 0;
    for (int c = 0; c < 19; c++) begin
      ledpat[18-c] = led1;
      if (done != 4'b0) early++;
      if (c > 0 && gnt != 4'b0) early++;
      if (busy !== 1'b1) early++;
      cyc();
    end
    chk("t1_led_pattern", 32'(ledpat), 32'h78780);
    chk("t1_no_early", 32'(early), 32'h0);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_busy_in_done", 32'(busy), 32'h1);
    cyc();
    chk("t1_idle_after", 32'({busy, done, led1}), 32'h0);

    // zero-count request from requester 2
    req_blinks = 16'h0000;
    req        = 4'b0100;
    cyc();
    chk("t2_gnt", 32'(gnt), 32'h4);
    req   = '0;
    lit   = 0;
    early = 0;
    for (int c = 0; c < 3; c++) begin
      if (led1) lit++;
      if (done != 4'b0) early++;
      cyc();
    end
    chk("t2_led_dark", 32'(lit), 32'h0);
    chk("t2_no_early", 32'(early), 32'h0);
    chk("t2_done", 32'(done), 32'h4);
    cyc();

    // all four requesting, one blink each, held throughout
    do_reset();
    req_blinks = 16'h1111;
    req        = 4'b1111;
    ng         = 0;
    lastdone   = -100;
    order      = '0;
    for (int cn = 0; cn < 200 && ng < 5; cn++) begin
      if (gnt != 4'b0) begin
        order = {order[15:0], gnt};
        if (ng > 0) chk("t3_gnt_after_done", 32'(cn - lastdone), 32'h1);
        ng++;
      end
      if (done != 4'b0) lastdone = cn;
      cyc();
    end
    chk("t3_grant_count", 32'(ng), 32'h5);
    chk("t3_grant_order", 32'(order), 32'h12481);
    req = '0;

    // reset during the second ON phase of a 3-blink burst
    do_reset();
    req_blinks = 16'h0300;
    req        = 4'b0100;
    cyc();
    chk("t4_gnt", 32'(gnt), 32'h4);
    req = '0;
    for (int c = 0; c < 9; c++) cyc();
    chk("t4_second_on", 32'(led1), 32'h1);
    rst = 1'b1;
    #1;
    chk("t4_async_clear", 32'({led1, busy}), 32'h0);
    cyc();
    rst   = 1'b0;
    early = 0;
    for (int c = 0; c < 30; c++) begin
      if (done != 4'b0 || busy || led1) early++;
      cyc();
    end
    chk("t4_abandoned", 32'(early), 32'h0);
    req = 4'b1001;
    cyc();
    chk("t4_ptr_cleared", 32'(gnt), 32'h1);
    req = '0;
    for (int c = 0; c < 3; c++) cyc();
    chk("t4_zero_done", 32'(done), 32'h1);
    cyc();

    // maximum count from requester 0
    req_blinks = 16'h000F;
    req        = 4'b0001;
    cyc();
    chk("t5_gnt", 32'(gnt), 32'h1);
    req   = '0;
    rises = 0;
    prev  = 1'b0;
    early = 0;
    for (int c = 0; c < 123; c++) begin
      if (led1 && !prev) rises++;
      prev = led1;
      if (done != 4'b0) early++;
      cyc();
    end
    chk("t5_rises", 32'(rises), 32'd15);
    chk("t5_no_early", 32'(early), 32'h0);
    chk("t5_done", 32'(done), 32'h1);
    cyc();

    // blink count changed while busy must not alter the burst
    req_blinks = 16'h0020;
    req        = 4'b0010;
    cyc();
    chk("t6_gnt", 32'(gnt), 32'h2);
    req        = '0;
    req_blinks = 16'h0090;
    ledpat     = '0;
    for (int c = 0; c < 19; c++) begin
      ledpat[18-c] = led1;
      cyc();
    end
    chk("t6_led_pattern", 32'(ledpat), 32'h78780);
    chk("t6_done", 32'(done), 32'h2);
    cyc();
    chk("t6_idle_after", 32'({busy, led1}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
